// File: rtl/chip8_draw_engine.sv
// chip8_draw_engine: CHIP-8 DXYN/00E0 unit owning a 1-bit framebuffer with XOR draw and collision.
// Define CHIP8_DRAW_WRAP_EN to wrap sprite pixels around the screen edges instead of clipping.
module chip8_draw_engine #(
  parameter int SCREEN_W = 64,
  parameter int SCREEN_H = 32,
  parameter int RAM_ADDR_W = 12,
  parameter int RAM_LATENCY = 2,
  localparam int XW = $clog2(SCREEN_W),
  localparam int YW = $clog2(SCREEN_H)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [7:0]            x_in,
  input  logic [7:0]            y_in,
  input  logic [3:0]            n_in,
  input  logic [RAM_ADDR_W-1:0] i_in,
  output logic                  busy,
  output logic                  done,
  output logic                  collision,
  output logic [RAM_ADDR_W-1:0] ram_address_out,
  output logic                  ram_read,
  input  logic [7:0]            ram_data_in,
  input  logic [XW-1:0]         disp_x,
  input  logic [YW-1:0]         disp_y,
  output logic                  disp_pixel
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, CLEAR, DONE} state_t;
  state_t state;
  logic [SCREEN_H-1:0][SCREEN_W-1:0] fb;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [3:0] n, row, next_row;
  logic [RAM_ADDR_W-1:0] base;
  logic [2:0] bit_idx, wait_cnt;
  logic [7:0] sprite;
  logic [YW-1:0] clr_row;
  logic [XW:0] px;
  logic [YW+3:0] py;
  logic on_screen, wr, old, hit;
  logic unused_ok;
  // px/py keep carry bits so clipping can see sprite extent past the edge
  assign px = {1'b0, x0} + (XW+1)'(bit_idx);
  assign py = (YW+4)'(y0) + (YW+4)'(row);
  assign next_row = row + 4'd1;
`ifdef CHIP8_DRAW_WRAP_EN
  assign on_screen = 1'b1;
`else
  assign on_screen = px < (XW+1)'(SCREEN_W) && py < (YW+4)'(SCREEN_H);
`endif
  assign wr = state == DRAW && sprite[3'd7 - bit_idx] && on_screen;
  assign old = fb[py[YW-1:0]][px[XW-1:0]];
  assign hit = wr && old;
  assign unused_ok = &{1'b0, x_in, y_in, px, py};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      collision <= 1'b0;
      ram_read <= 1'b0;
      ram_address_out <= '0;
      x0 <= '0;
      y0 <= '0;
      n <= '0;
      base <= '0;
      row <= '0;
      bit_idx <= '0;
      wait_cnt <= '0;
      sprite <= '0;
      clr_row <= '0;
    end else begin
      done <= 1'b0;
      ram_read <= 1'b0;
      case (state)
        IDLE:
          if (clear) begin
            state <= CLEAR;
            busy <= 1'b1;
            clr_row <= '0;
          end else if (start) begin
            x0 <= x_in[XW-1:0];
            y0 <= y_in[YW-1:0];
            n <= n_in;
            base <= i_in;
            row <= '0;
            collision <= 1'b0;
            if (n_in == 4'd0) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= FETCH;
              busy <= 1'b1;
              ram_read <= 1'b1;
              ram_address_out <= i_in;
            end
          end
        FETCH: begin
          state <= WAIT;
          wait_cnt <= '0;
        end
        WAIT:
          if (wait_cnt == 3'(RAM_LATENCY - 1)) begin
            sprite <= ram_data_in;
            bit_idx <= '0;
            state <= DRAW;
          end else wait_cnt <= wait_cnt + 3'd1;
        DRAW: begin
          if (hit) collision <= 1'b1;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            row <= next_row;
            if (next_row == n) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              state <= FETCH;
              ram_read <= 1'b1;
              ram_address_out <= base + RAM_ADDR_W'(next_row);
            end
          end
        end
        CLEAR: begin
          clr_row <= clr_row + 1'b1;
          if (clr_row == YW'(SCREEN_H - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // read-before-write: the scanout sees the pre-update value on a same-cycle write
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fb <= '0;
      disp_pixel <= 1'b0;
    end else begin
      disp_pixel <= fb[disp_y][disp_x];
      if (state == CLEAR) fb[clr_row] <= '0;
      else if (wr) fb[py[YW-1:0]][px[XW-1:0]] <= ~old;
    end
endmodule

// File: tb/tb_chip8_draw_engine.sv
// tb_chip8_draw_engine: randomized and directed checks of the draw engine against a pixel-level model.
module tb_chip8_draw_engine;
  localparam int W = 64, H = 32, AW = 12, L = 2;
`ifdef CHIP8_DRAW_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, clear = 1'b0;
  logic [7:0] x_in = '0, y_in = '0;
  logic [3:0] n_in = '0;
  logic [AW-1:0] i_in = '0;
  logic busy, done, collision, ram_read, disp_pixel;
  logic [AW-1:0] ram_address_out;
  logic [7:0] ram_data_in;
  logic [5:0] disp_x = '0;
  logic [4:0] disp_y = '0;
  logic [7:0] mem [4096];
  logic [7:0] pipe [L];
  int rd_cnt = 0, done_cnt = 0, vecs = 0, errs = 0;
  logic [AW-1:0] rd_q [$];
  bit mfb [H][W];
  bit mcol = 1'b0;

  chip8_draw_engine #(.SCREEN_W(W), .SCREEN_H(H), .RAM_ADDR_W(AW), .RAM_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .x_in(x_in), .y_in(y_in),
    .n_in(n_in), .i_in(i_in), .busy(busy), .done(done), .collision(collision),
    .ram_address_out(ram_address_out), .ram_read(ram_read), .ram_data_in(ram_data_in),
    .disp_x(disp_x), .disp_y(disp_y), .disp_pixel(disp_pixel));

  always #5 clock = ~clock;

  // RAM returns the byte at the current address L cycles after it changes
  always @(posedge clock) begin
    pipe[0] <= mem[ram_address_out];
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_data_in = pipe[L-1];

  always @(posedge clock) begin
    if (ram_read) begin
      rd_cnt <= rd_cnt + 1;
      rd_q.push_back(ram_address_out);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) mfb[y][x] = 1'b0;
  endtask

  task automatic model_draw(input int x, input int y, input int n, input int i);
    logic [7:0] b;
    int px, py;
    mcol = 1'b0;
    for (int r = 0; r < n; r++) begin
      b = mem[(i + r) % 4096];
      for (int c = 0; c < 8; c++) if (b[7-c]) begin
        px = x % W + c;
        py = y % H + r;
        if (WRAP) begin
          px = px % W;
          py = py % H;
        end
        if (px < W && py < H) begin
          if (mfb[py][px]) mcol = 1'b1;
          mfb[py][px] = ~mfb[py][px];
        end
      end
    end
  endtask

  task automatic check_screen(input string tag);
    int bad = 0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin
      @(negedge clock);
      disp_x = 6'(x);
      disp_y = 5'(y);
      @(posedge clock);
      #1;
      if (disp_pixel !== mfb[y][x]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic run_draw(input int x, input int y, input int n, input int i, input bit poke);
    int lat = 0, r0 = rd_cnt, d0 = done_cnt, q0 = rd_q.size(), bad = 0;
    model_draw(x, y, n, i);
    @(negedge clock);
    x_in = 8'(x);
    y_in = 8'(y);
    n_in = 4'(n);
    i_in = AW'(i);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    while (done !== 1'b1 && lat < 1000) begin
      if (poke) begin
        start = lat == 3;
        clear = lat == 4;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
    clear = 1'b0;
    check("draw_latency", lat, n == 0 ? 0 : n * (L + 9));
    check("busy_at_done", busy, 0);
    check("collision", collision, mcol);
    @(posedge clock);
    #1;
    check("done_one_cycle", done, 0);
    repeat (20) @(posedge clock);
    #1;
    check("done_count", done_cnt - d0, 1);
    check("ram_reads", rd_cnt - r0, n);
    for (int r = 0; r < n; r++)
      if (q0 + r >= rd_q.size() || rd_q[q0 + r] !== AW'(i + r)) bad++;
    check("ram_addrs", bad, 0);
    check("collision_held", collision, mcol);
  endtask

  task automatic run_clear(input bit with_start);
    int lat = 0, bsy = 0, r0 = rd_cnt, d0 = done_cnt;
    model_clear();
    @(negedge clock);
    clear = 1'b1;
    start = with_start;
    n_in = 4'd1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    start = 1'b0;
    while (done !== 1'b1 && lat < 1000) begin
      if (busy) bsy++;
      start = lat == 5;
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
    check("clear_latency", lat, H);
    check("clear_busy_cycles", bsy, H);
    repeat (20) @(posedge clock);
    #1;
    check("clear_done_count", done_cnt - d0, 1);
    check("clear_no_reads", rd_cnt - r0, 0);
    check("clear_idle", busy, 0);
    check("clear_collision", collision, mcol);
  endtask

  initial begin
    int d0;
    for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
    model_clear();
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_collision", collision, 0);
    check("rst_ram_read", ram_read, 0);
    check("rst_ram_addr", ram_address_out, 0);
    check("rst_disp", disp_pixel, 0);
    @(negedge clock) reset = 1'b0;
    // populate, then reset in the middle of a colliding redraw
    mem[12'h100] = 8'hFF;
    run_draw(10, 5, 1, 12'h100, 1'b0);
    d0 = done_cnt;
    @(negedge clock);
    x_in = 8'd10;
    y_in = 8'd5;
    n_in = 4'd1;
    i_in = 12'h100;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_collision", collision, 0);
    @(negedge clock) reset = 1'b0;
    model_clear();
    mcol = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check_screen("midrst_screen");
    mem[12'h050] = 8'hF0;
    run_draw(0, 0, 1, 12'h050, 1'b0);
    check_screen("f0_screen");
    run_draw(0, 0, 1, 12'h050, 1'b0);
    check("repeat_collides", collision, 1);
    check_screen("f0_repeat_screen");
    mem[12'h050] = 8'h0F;
    run_draw(0, 0, 1, 12'h050, 1'b0);
    check("0f_no_collision", collision, 0);
    check_screen("0f_screen");
    run_clear(1'b0);
    mem[12'h200] = 8'hFF;
    mem[12'h201] = 8'hFF;
    run_draw(62, 31, 2, 12'h200, 1'b0);
    check_screen("corner_screen");
    mem[12'h300] = 8'h80;
    run_draw(70, 40, 1, 12'h300, 1'b1);
    check_screen("origin_wrap_screen");
    run_draw(5, 5, 0, 12'h300, 1'b0);
    check("n0_collision", collision, 0);
    run_clear(1'b1);
    check_screen("clear_screen");
    for (int t = 0; t < 12; t++) begin
      int i = $urandom_range(0, 4095);
      for (int r = 0; r < 16; r++) mem[(i + r) % 4096] = 8'($urandom);
      if (t == 6) run_clear(1'b0);
      run_draw($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15), i, t % 3 == 1);
      if (t % 4 == 3) check_screen("random_screen");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
